// File: rtl/analog_to_digital.sv
// analog_to_digital: SPI ADC frame reader, 500 kHz spi_sck from clk_1MHz, 12-bit result.
// Optional macro ADC_LEADING_ZERO_CHECK_EN flags nonzero leading frame bits on frame_err.
module analog_to_digital #(
    parameter int FRAME_BITS   = 16,
    parameter int QUIET_CYCLES = 2
) (
    input  logic        clk_1MHz,
    input  logic        rst,
    input  logic        start,
    input  logic        spi_miso,
    output logic        spi_sck,
    output logic        spi_cs,
    output logic [11:0] value_out,
    output logic        value_valid,
    output logic        busy,
    output logic        frame_err
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] CONV  = 2'd1;
    localparam logic [1:0] QUIET = 2'd2;
    localparam int CW = $clog2(2 * FRAME_BITS) > 4 ? $clog2(2 * FRAME_BITS) : 4;
    localparam logic [CW-1:0] CONV_LAST  = CW'(2 * FRAME_BITS - 1);
    localparam logic [CW-1:0] QUIET_LAST = CW'(QUIET_CYCLES - 1);

    logic [1:0]            r_state;
    logic [CW-1:0]         r_cnt;
    logic [FRAME_BITS-1:0] r_shift;
    logic                  r_sck;
    logic                  r_cs;
    logic                  r_valid;
    logic [11:0]           r_value;
    logic                  w_conv_end;
    logic                  w_quiet_end;
    logic                  w_go;

    assign w_conv_end  = r_state == CONV && r_cnt == CONV_LAST;
    assign w_quiet_end = r_state == QUIET && r_cnt == QUIET_LAST;
    assign w_go        = start && (r_state == IDLE || w_quiet_end);

    // r_cnt numbers CONV cycles; sck for the next cycle is high when the current one is even
    always_ff @(posedge clk_1MHz) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_shift <= '0;
            r_sck   <= 1'b1;
            r_cs    <= 1'b1;
            r_value <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= w_conv_end;
            if (w_go) begin
                r_state <= CONV;
                r_cnt   <= '0;
                r_cs    <= 1'b0;
                r_sck   <= 1'b0;
            end else if (w_conv_end) begin
                r_state <= QUIET;
                r_cnt   <= '0;
                r_cs    <= 1'b1;
                r_sck   <= 1'b1;
                r_value <= r_shift[11:0];
            end else if (r_state == CONV) begin
                r_cnt <= r_cnt + 1'b1;
                r_sck <= ~r_cnt[0];
                if (!r_cnt[0])
                    r_shift <= {r_shift[FRAME_BITS-2:0], spi_miso};
            end else if (r_state == QUIET && !w_quiet_end) begin
                r_cnt <= r_cnt + 1'b1;
            end else begin
                r_state <= IDLE;
                r_cnt   <= '0;
                r_cs    <= 1'b1;
                r_sck   <= 1'b1;
            end
        end
    end

`ifdef ADC_LEADING_ZERO_CHECK_EN
    logic r_err;

    always_ff @(posedge clk_1MHz) begin
        if (rst)
            r_err <= 1'b0;
        else if (w_conv_end)
            r_err <= |(r_shift >> 12);
    end

    assign frame_err = r_err;
`else
    assign frame_err = 1'b0;
`endif

    assign spi_sck     = r_sck;
    assign spi_cs      = r_cs;
    assign value_out   = r_value;
    assign value_valid = r_valid;
    assign busy        = r_state == CONV || r_state == QUIET;
endmodule

// File: tb/tb_analog_to_digital.sv
// tb_analog_to_digital: scoreboard bench with an SPI ADC model and frame-shape monitor.
module tb_analog_to_digital;
    localparam int FB = 16;
    localparam int QC = 2;
`ifdef ADC_LEADING_ZERO_CHECK_EN
    localparam bit EN = 1'b1;
`else
    localparam bit EN = 1'b0;
`endif

    logic        clk_1MHz = 1'b0;
    logic        rst      = 1'b1;
    logic        start    = 1'b0;
    logic        spi_miso = 1'b0;
    logic        spi_sck;
    logic        spi_cs;
    logic [11:0] value_out;
    logic        value_valid;
    logic        busy;
    logic        frame_err;

    int n_chk   = 0;
    int n_fail  = 0;
    int nframes = 0;
    logic b2b   = 1'b0;
    logic [FB-1:0] adc_q[$];
    logic [12:0]   exp_q[$];

    analog_to_digital #(.FRAME_BITS(FB), .QUIET_CYCLES(QC)) dut (
        .clk_1MHz   (clk_1MHz),
        .rst        (rst),
        .start      (start),
        .spi_miso   (spi_miso),
        .spi_sck    (spi_sck),
        .spi_cs     (spi_cs),
        .value_out  (value_out),
        .value_valid(value_valid),
        .busy       (busy),
        .frame_err  (frame_err)
    );

    always #5 clk_1MHz = ~clk_1MHz;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic lead_err(input logic [FB-1:0] w);
        return EN && ((w >> 12) != 0);
    endfunction

    // ADC model: presents the next bit while sck is low, advances after each sck high
    logic [FB-1:0] adc_word = '0;
    int   adc_idx     = 0;
    logic adc_prev_cs = 1'b1;
    always @(negedge clk_1MHz) begin
        if (adc_prev_cs && !spi_cs) begin
            adc_word = '0;
            if (adc_q.size() > 0) adc_word = adc_q.pop_front();
            adc_idx = FB - 1;
        end
        if (!spi_cs && !spi_sck) spi_miso = adc_word[adc_idx];
        else if (!spi_cs && spi_sck) adc_idx--;
        adc_prev_cs = spi_cs;
    end

    logic m_prev_cs = 1'b1, m_prev_sck = 1'b1, m_prev_valid = 1'b0;
    logic m_skip = 1'b0, m_had = 1'b0;
    int   rises = 0, lowc = 0, hic = 0, lat = 0;
    logic [11:0] hold_val = '0;
    logic        hold_err = 1'b0;
    logic [12:0] e;
    always @(negedge clk_1MHz) begin
        if (rst) begin
            exp_q.delete();
            hold_val = '0;
            hold_err = 1'b0;
            m_skip   = !spi_cs;
            m_had    = 1'b0;
        end else begin
            if (value_valid) begin
                chk("valid_pulse_width", m_prev_valid, 0);
                chk("valid_latency", lat, 2 * FB);
                n_chk++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_valid: got value %0h with no frame pending", value_out);
                end else begin
                    e = exp_q.pop_front();
                    hold_val = e[11:0];
                    hold_err = e[12];
                end
            end
            chk("value_out", value_out, hold_val);
            chk("frame_err", frame_err, hold_err);
            if (!spi_cs) begin
                if (m_prev_cs) begin
                    nframes++;
                    if (b2b && m_had) chk("quiet_gap", hic, QC);
                    lat = 0; rises = 0; lowc = 0;
                end
                lowc++;
                if (spi_sck && !m_prev_sck) rises++;
            end else begin
                if (!m_prev_cs) begin
                    if (!m_skip) begin
                        chk("sck_rises", rises, FB);
                        chk("cs_low_cycles", lowc, 2 * FB);
                    end
                    m_skip = 1'b0;
                    m_had  = 1'b1;
                    hic    = 0;
                end
                hic++;
                chk("sck_idle_high", spi_sck, 1);
            end
            lat++;
        end
        m_prev_cs    = spi_cs;
        m_prev_sck   = spi_sck;
        m_prev_valid = value_valid;
    end

    task automatic tick();
        @(posedge clk_1MHz);
        #2;
    endtask

    task automatic issue(input logic [FB-1:0] w);
        adc_q.push_back(w);
        exp_q.push_back({lead_err(w), w[11:0]});
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy || exp_q.size() > 0) && n < 400) begin
            tick();
            n++;
        end
        n_chk++;
        if (busy || exp_q.size() > 0) begin
            n_fail++;
            $display("FAIL wait_idle: busy=%0d pending=%0d after %0d cycles", busy, exp_q.size(), n);
        end
    endtask

    task automatic wait_frames(input int target);
        int n = 0;
        while (nframes < target && n < 200) begin
            tick();
            n++;
        end
        n_chk++;
        if (nframes < target) begin
            n_fail++;
            $display("FAIL wait_frames: got %0d frames required %0d", nframes, target);
        end
    endtask

    initial begin
        int base;
        logic [FB-1:0] w1, w2;
        repeat (3) tick();
        chk("rst_cs", spi_cs, 1);
        chk("rst_sck", spi_sck, 1);
        chk("rst_value", value_out, 0);
        chk("rst_valid", value_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", frame_err, 0);
        rst = 1'b0;
        tick();

        base = nframes;
        issue(16'h0ABC);
        pulse_start();
        chk("busy_conv", busy, 1);
        wait_idle();
        chk("single_value", value_out, 12'hABC);
        chk("single_frames", nframes, base + 1);

        base = nframes;
        issue(16'h0001); issue(16'h0FFF); issue(16'h0800);
        start = 1'b1;
        wait_frames(base + 1);
        b2b = 1'b1;
        wait_frames(base + 3);
        start = 1'b0;
        wait_idle();
        b2b = 1'b0;
        chk("held_last_value", value_out, 12'h800);
        chk("held_frames", nframes, base + 3);

        issue(16'h0555);
        pulse_start();
        repeat (10) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_cs", spi_cs, 1);
        chk("abort_sck", spi_sck, 1);
        chk("abort_valid", value_valid, 0);
        chk("abort_value", value_out, 0);
        chk("abort_busy", busy, 0);
        repeat (40) tick();
        chk("abort_value_later", value_out, 0);

        base = nframes;
        issue(16'h0321);
        pulse_start();
        repeat (5) tick();
        pulse_start();
        repeat (26) tick();
        pulse_start();
        wait_idle();
        repeat (5) tick();
        chk("ignore_frames", nframes, base + 1);
        chk("ignore_idle", busy, 0);
        chk("ignore_value", value_out, 12'h321);

        issue(16'h8123);
        pulse_start();
        wait_idle();
        chk("lead_value", value_out, 12'h123);
        chk("lead_err_set", frame_err, int'(EN));
        issue(16'h0123);
        pulse_start();
        wait_idle();
        chk("lead_err_clear", frame_err, 0);

        for (int i = 0; i < 20; i++) begin
            repeat ($urandom_range(0, 4)) tick();
            w1 = FB'($urandom);
            w2 = FB'($urandom);
            if ($urandom_range(0, 2) == 0) begin
                base = nframes;
                issue(w1); issue(w2);
                start = 1'b1;
                wait_frames(base + 1);
                b2b = 1'b1;
                wait_frames(base + 2);
                start = 1'b0;
                wait_idle();
                b2b = 1'b0;
            end else begin
                issue(w1);
                pulse_start();
                wait_idle();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
